usb_rx_packet_ctrl: RTL
=======================

# usb_rx_packet_ctrl

Parametrised USB full-speed receive packet controller. It sits between the bit-level RX front end (sync detect, NRZI decode, unstuffing, byte assembly, CRC5/CRC16 checkers) and the endpoint RX buffer. It classifies packets, filters tokens by device address and endpoint, and strips the CRC16 from data payloads. It also tracks DATA0/DATA1 toggles per endpoint and reports one result code per packet.

## Interface
- DEV_ADDR, 7'd0: device address that tokens must match.
- NUM_EP, 4: number of endpoints (1..16); toggle state is kept per endpoint.
- MAX_PKT, 64: maximum payload bytes per data packet, excluding CRC16.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sync_det  in  1  one-cycle pulse when a SYNC pattern completes.
- byte_valid  in  1  one-cycle pulse; rx_byte holds a new byte.
- rx_byte  in  8  received byte, LSB = first bit on the wire.
- eop  in  1  one-cycle pulse when EOP is detected.
- crc5_ok  in  1  CRC5 residue check result; valid in the eop cycle.
- crc16_ok  in  1  CRC16 residue check result; valid in the eop cycle.
- clear_crc  out  1  pulse that resets both CRC checkers.
- data_we  out  1  payload write strobe to the RX buffer.
- data_out  out  8  payload byte; valid while data_we is high.
- pkt_done  out  1  one-cycle pulse; rx_pid, rx_ep and rx_count are updated.
- rx_pid  out  4  result code: 0 IDLE, 1 DATA, 2 OUT, 3 IN, 4 ACK, 5 NAK, 6 BAD, 7 STALL, 8 SETUP, 9 DATA_DUP.
- rx_ep  out  4  endpoint of the last token, or of the endpoint the data was attributed to.
- rx_count  out  $clog2(MAX_PKT+1)  payload byte count of the last data packet.

## Operation
- PID byte format: bits 3:0 hold the PID; bits 7:4 must equal the bitwise inverse of bits 3:0. Decoded values:
  - Tokens: OUT 0xE1, IN 0x69, SETUP 0x2D.
  - Data: DATA0 0xC3, DATA1 0x4B.
  - Handshakes: ACK 0xD2, NAK 0x5A, STALL 0x1E.
  - Ignored: SOF 0xA5.
- States: IDLE, PID, TOK1, TOK2, TOK_EOP, DATA, HSK_EOP, DRAIN, DONE.
- IDLE: on sync_det go to PID.
- PID: on byte_valid decode the byte.
  - Token → TOK1. DATAx → DATA. Handshake → HSK_EOP.
  - Check-nibble mismatch → DRAIN with result BAD.
  - SOF or any other well-formed PID → DRAIN silently (no pkt_done).
  - Pulse clear_crc when a token or DATAx PID is decoded.
- TOK1 takes the first token byte, TOK2 the second.
  - Token fields: addr = byte1[6:0]; ep = {byte2[2:0], byte1[7]}.
- TOK_EOP: on eop, evaluate the token in this order:
  - crc5_ok low → BAD.
  - addr ≠ DEV_ADDR, or ep ≥ NUM_EP → silent, no pkt_done.
  - Otherwise: result OUT, IN or SETUP, and rx_ep = ep.
  - On OUT or SETUP, latch ep and set the armed flag.
  - On SETUP, also clear that endpoint's expected toggle to 0.
- DATA: payload passes through a 2-byte holding pipeline so the CRC16 bytes are never written.
  - Each byte_valid arriving while 2 bytes are held emits the oldest byte with data_we and increments the count.
  - Writing a byte that would make count > MAX_PKT → DRAIN with BAD; no further writes.
  - On eop: held bytes < 2, crc16_ok low, or armed flag clear → BAD.
  - Otherwise compare the PID toggle (DATA1 = 1) with the expected toggle of the latched ep:
    - Equal → result DATA and flip the expected toggle.
    - Different → result DATA_DUP; toggle unchanged.
  - Any data packet end clears the armed flag.
- HSK_EOP: eop with no byte received → ACK, NAK or STALL. A byte_valid before eop → DRAIN with BAD.
- eop early in TOK1/TOK2, or byte_valid in TOK_EOP → BAD. Early eop goes to DONE; byte_valid goes to DRAIN.
- DRAIN: wait for eop, then go to DONE if a result is pending, else to IDLE.
- DONE: pulse pkt_done, return to IDLE.
- Any new token disarms before re-evaluation. IN and handshake packets also clear the armed flag.
- sync_det in any non-IDLE state aborts the current packet silently:
  - Holding pipeline flushed, armed flag unchanged, next state PID.
- Writes already issued for an aborted or BAD packet are not retracted; the buffer discards on a BAD result.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0; rx_pid = IDLE.
  - All endpoint toggles 0; armed flag 0; holding pipeline empty.
- All outputs are registered.
- clear_crc: the cycle after the PID byte_valid.
- data_we/data_out: the cycle after the pushing byte_valid.
- pkt_done: 2 cycles after eop (eop → DONE → pulse). rx_pid, rx_ep and rx_count update in the same cycle as pkt_done and hold until the next pkt_done.
- byte_valid and eop in the same cycle: process the byte first, then the eop.
- Minimum spacing: back-to-back packets with sync_det ≥ 3 cycles after eop are fully handled.

## Test plan
- OUT token to addr 0, ep 2 (PID 0xE1, byte1 0x00, byte2 0x01 plus CRC bits, crc5_ok=1) → pkt_done, rx_pid=2, rx_ep=2.
- Same OUT, then DATA0 0xC3 with 4 payload + 2 CRC bytes and crc16_ok=1 → exactly 4 data_we with matching bytes, rx_pid=1, rx_count=4. Repeat with DATA0 → rx_pid=9 (DUP).
- DATA1 with MAX_PKT+1 payload bytes → exactly MAX_PKT writes, rx_pid=6.
- Token to addr 5 with DEV_ADDR=0 → no pkt_done. PID 0xE2 (bad check nibble) → rx_pid=6.
- ACK 0xD2 then eop → rx_pid=4. NAK followed by an extra byte → rx_pid=6.
- rst asserted mid-DATA, and sync_det mid-DATA → no pkt_done, outputs per reset/abort rules, and the next valid packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_packet_ctrl
// Brief    : USB FS receive packet classifier, token filter, CRC16 stripper
//            and per-endpoint DATA0/DATA1 toggle tracker.
// Revision : 1.0
// ============================================================================
module usb_rx_packet_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'd0,
    parameter int         NUM_EP   = 4,
    parameter int         MAX_PKT  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sync_det,
    input  logic                           byte_valid,
    input  logic [7:0]                     rx_byte,
    input  logic                           eop,
    input  logic                           crc5_ok,
    input  logic                           crc16_ok,
    output logic                           clear_crc,
    output logic                           data_we,
    output logic [7:0]                     data_out,
    output logic                           pkt_done,
    output logic [3:0]                     rx_pid,
    output logic [3:0]                     rx_ep,
    output logic [$clog2(MAX_PKT+1)-1:0]   rx_count
);
    localparam int              c_CW      = $clog2(MAX_PKT + 1);
    localparam int              c_EPW     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam logic [c_CW-1:0] c_MAX     = c_CW'(MAX_PKT);
    localparam logic [4:0]      c_NUM_EP5 = 5'(NUM_EP);

    localparam logic [3:0] c_RES_DATA  = 4'd1;
    localparam logic [3:0] c_RES_OUT   = 4'd2;
    localparam logic [3:0] c_RES_IN    = 4'd3;
    localparam logic [3:0] c_RES_ACK   = 4'd4;
    localparam logic [3:0] c_RES_NAK   = 4'd5;
    localparam logic [3:0] c_RES_BAD   = 4'd6;
    localparam logic [3:0] c_RES_STALL = 4'd7;
    localparam logic [3:0] c_RES_SETUP = 4'd8;
    localparam logic [3:0] c_RES_DUP   = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PID     = 4'd1,
        S_TOK1    = 4'd2,
        S_TOK2    = 4'd3,
        S_TOK_EOP = 4'd4,
        S_DATA    = 4'd5,
        S_HSK_EOP = 4'd6,
        S_DRAIN   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_byte1;
    logic [2:0]        r_byte2_lo;
    logic [3:0]        r_pkt_code;
    logic              r_data_tgl;
    logic [7:0]        r_hold0, r_hold1;
    logic [1:0]        r_held;
    logic [c_CW-1:0]   r_count;
    logic [NUM_EP-1:0] r_toggle;
    logic              r_armed;
    logic [c_EPW-1:0]  r_arm_ep;
    logic              r_pend;
    logic [3:0]        r_res_pid, r_res_ep;
    logic [c_CW-1:0]   r_res_cnt;

    logic       w_chk_ok, w_is_tok, w_is_data, w_is_hsk;
    logic [3:0] w_pid_code, w_tok_ep, w_res_pid, w_res_ep;
    logic [2:0] w_byte2_lo;
    logic       w_tok_match, w_dup;
    logic [1:0] w_held_post;
    logic [c_CW-1:0] w_cnt_post;
    logic       w_clear_crc, w_push, w_res_load, w_res_ep_load, w_res_cnt_load;
    logic       w_arm_set, w_arm_clr, w_tgl_clr, w_tgl_flip, w_bad;
    logic       w_tok_eval, w_data_eval;

    assign w_chk_ok  = (rx_byte[7:4] == ~rx_byte[3:0]);
    assign w_is_tok  = (rx_byte[3:0] == 4'h1) || (rx_byte[3:0] == 4'h9) || (rx_byte[3:0] == 4'hD);
    assign w_is_data = (rx_byte[3:0] == 4'h3) || (rx_byte[3:0] == 4'hB);
    assign w_is_hsk  = (rx_byte[3:0] == 4'h2) || (rx_byte[3:0] == 4'hA) || (rx_byte[3:0] == 4'hE);

    always_comb begin
        w_pid_code = 4'd0;
        case (rx_byte[3:0])
            4'h1:    w_pid_code = c_RES_OUT;
            4'h9:    w_pid_code = c_RES_IN;
            4'hD:    w_pid_code = c_RES_SETUP;
            4'h2:    w_pid_code = c_RES_ACK;
            4'hA:    w_pid_code = c_RES_NAK;
            4'hE:    w_pid_code = c_RES_STALL;
            default: w_pid_code = 4'd0;
        endcase
    end

    // Second token byte may arrive in the same cycle as its eop.
    assign w_byte2_lo  = (r_state == S_TOK2) ? rx_byte[2:0] : r_byte2_lo;
    assign w_tok_ep    = {w_byte2_lo, r_byte1[7]};
    assign w_tok_match = (r_byte1[6:0] == DEV_ADDR) && ({1'b0, w_tok_ep} < c_NUM_EP5);
    assign w_held_post = (byte_valid && (r_held != 2'd2)) ? r_held + 2'd1 : r_held;
    assign w_cnt_post  = r_count + c_CW'(w_push);
    assign w_dup       = (r_data_tgl != r_toggle[r_arm_ep]);

    always_comb begin
        w_next         = r_state;
        w_clear_crc    = 1'b0;
        w_push         = 1'b0;
        w_res_load     = 1'b0;
        w_res_pid      = c_RES_BAD;
        w_res_ep_load  = 1'b0;
        w_res_ep       = w_tok_ep;
        w_res_cnt_load = 1'b0;
        w_arm_set      = 1'b0;
        w_arm_clr      = 1'b0;
        w_tgl_clr      = 1'b0;
        w_tgl_flip     = 1'b0;
        w_bad          = 1'b0;
        w_tok_eval     = 1'b0;
        w_data_eval    = 1'b0;
        if (sync_det) begin
            w_next = S_PID;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_PID: begin
                    if (byte_valid) begin
                        if (!w_chk_ok) begin
                            w_bad = 1'b1;
                        end else if (w_is_tok) begin
                            w_clear_crc = 1'b1;
                            w_arm_clr   = 1'b1;
                            w_next      = S_TOK1;
                            w_bad       = eop;
                        end else if (w_is_data) begin
                            w_clear_crc = 1'b1;
                            w_next      = S_DATA;
                            w_bad       = eop;
                            w_arm_clr   = eop;
                        end else if (w_is_hsk) begin
                            w_arm_clr = 1'b1;
                            w_next    = S_HSK_EOP;
                            if (eop) begin
                                w_res_load = 1'b1;
                                w_res_pid  = w_pid_code;
                                w_next     = S_DONE;
                            end
                        end else begin
                            w_next = eop ? S_IDLE : S_DRAIN;
                        end
                    end else if (eop) begin
                        w_next = S_IDLE;
                    end
                end
                S_TOK1: begin
                    if (byte_valid) w_next = S_TOK2;
                    w_bad = eop;
                end
                S_TOK2: begin
                    if (byte_valid) begin
                        w_next     = S_TOK_EOP;
                        w_tok_eval = eop;
                    end else begin
                        w_bad = eop;
                    end
                end
                S_TOK_EOP: begin
                    if (byte_valid) w_bad = 1'b1;
                    else            w_tok_eval = eop;
                end
                S_DATA: begin
                    if (byte_valid && (r_held == 2'd2) && (r_count == c_MAX)) begin
                        w_bad          = 1'b1;
                        w_arm_clr      = 1'b1;
                        w_res_cnt_load = 1'b1;
                    end else begin
                        w_push      = byte_valid && (r_held == 2'd2);
                        w_data_eval = eop;
                    end
                end
                S_HSK_EOP: begin
                    if (byte_valid) begin
                        w_bad = 1'b1;
                    end else if (eop) begin
                        w_res_load = 1'b1;
                        w_res_pid  = r_pkt_code;
                        w_next     = S_DONE;
                    end
                end
                S_DRAIN: if (eop) w_next = r_pend ? S_DONE : S_IDLE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end

        if (w_tok_eval) begin
            if (!crc5_ok) begin
                w_bad = 1'b1;
            end else if (!w_tok_match) begin
                w_next = S_IDLE;
            end else begin
                w_res_load    = 1'b1;
                w_res_pid     = r_pkt_code;
                w_res_ep_load = 1'b1;
                w_next        = S_DONE;
                w_arm_set     = (r_pkt_code != c_RES_IN);
                w_tgl_clr     = (r_pkt_code == c_RES_SETUP);
            end
        end

        if (w_data_eval) begin
            w_arm_clr      = 1'b1;
            w_res_cnt_load = 1'b1;
            if ((w_held_post != 2'd2) || !crc16_ok || !r_armed) begin
                w_bad = 1'b1;
            end else begin
                w_res_load    = 1'b1;
                w_res_pid     = w_dup ? c_RES_DUP : c_RES_DATA;
                w_res_ep_load = 1'b1;
                w_res_ep      = 4'(r_arm_ep);
                w_tgl_flip    = !w_dup;
                w_next        = S_DONE;
            end
        end

        if (w_bad) begin
            w_res_load = 1'b1;
            w_res_pid  = c_RES_BAD;
            w_next     = eop ? S_DONE : S_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte1    <= 8'd0;
            r_byte2_lo <= 3'd0;
            r_pkt_code <= 4'd0;
            r_data_tgl <= 1'b0;
            r_hold0    <= 8'd0;
            r_hold1    <= 8'd0;
            r_held     <= 2'd0;
            r_count    <= '0;
            r_toggle   <= '0;
            r_armed    <= 1'b0;
            r_arm_ep   <= '0;
            r_pend     <= 1'b0;
            r_res_pid  <= 4'd0;
            r_res_ep   <= 4'd0;
            r_res_cnt  <= '0;
            clear_crc  <= 1'b0;
            data_we    <= 1'b0;
            data_out   <= 8'd0;
            pkt_done   <= 1'b0;
            rx_pid     <= 4'd0;
            rx_ep      <= 4'd0;
            rx_count   <= '0;
        end else begin
            r_state   <= w_next;
            clear_crc <= w_clear_crc;
            data_we   <= w_push;
            pkt_done  <= (r_state == S_DONE);
            r_pend    <= w_res_load || (r_pend && (w_next != S_IDLE) && (w_next != S_PID));
            if (w_push) data_out <= r_hold0;
            if (r_state == S_DONE) begin
                rx_pid   <= r_res_pid;
                rx_ep    <= r_res_ep;
                rx_count <= r_res_cnt;
            end
            if (!sync_det && byte_valid) begin
                if (r_state == S_PID) begin
                    r_pkt_code <= w_pid_code;
                    r_data_tgl <= rx_byte[3];
                    r_held     <= 2'd0;
                    r_count    <= '0;
                end
                if (r_state == S_TOK1) r_byte1 <= rx_byte;
                if (r_state == S_TOK2) r_byte2_lo <= rx_byte[2:0];
                if (r_state == S_DATA) begin
                    case (r_held)
                        2'd0:    begin r_hold0 <= rx_byte; r_held <= 2'd1; end
                        2'd1:    begin r_hold1 <= rx_byte; r_held <= 2'd2; end
                        default: begin r_hold0 <= r_hold1; r_hold1 <= rx_byte; end
                    endcase
                end
            end
            if (w_push) r_count <= w_cnt_post;
            if (sync_det) r_held <= 2'd0;
            if (w_arm_set) begin
                r_armed  <= 1'b1;
                r_arm_ep <= w_tok_ep[c_EPW-1:0];
            end else if (w_arm_clr) begin
                r_armed <= 1'b0;
            end
            if (w_tgl_clr)  r_toggle[w_tok_ep[c_EPW-1:0]] <= 1'b0;
            if (w_tgl_flip) r_toggle[r_arm_ep] <= ~r_toggle[r_arm_ep];
            if (w_res_load)     r_res_pid <= w_res_pid;
            if (w_res_ep_load)  r_res_ep  <= w_res_ep;
            if (w_res_cnt_load) r_res_cnt <= w_cnt_post;
        end
    end

endmodule
`default_nettype wire
